seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed seven-segment digits (2..8).
REQ-002 SHALL have parameter DWELL, default 1000: clock cycles each digit is lit per visit (>=2).
REQ-003 SHALL have parameter BLANK, default 16: all-digits-off cycles before each digit is lit (>=1), for ghosting suppression.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  asynchronous reset, active low.
REQ-006 i_valid  input  1  producer offers a new display value.
REQ-007 i_value  input  4*NDIG  new value; nibble k (bits 4k+3:4k) is digit k, where digit 0 is least significant.
REQ-008 i_lzb  input  1  leading-zero blanking enable; sampled every cycle.
REQ-009 o_ready  output  1  pending buffer is empty, so a value can be accepted.
REQ-010 o_seg  output  7  segment drive, active high, bit 6 = a ... bit 0 = g.
REQ-011 o_an  output  NDIG  digit enable, one-hot or zero, active high.
REQ-012 o_frame  output  1  one-cycle pulse when a full scan completes.

Function
REQ-013 SHALL implement FSM {BLANK, SHOW} with digit index dig (0..NDIG-1) and a dwell counter cnt.
REQ-014 BLANK: when cnt reaches BLANK-1, SHALL go to SHOW with cnt=0; otherwise cnt increments.
REQ-015 SHOW: when cnt reaches DWELL-1, SHALL go to BLANK with cnt=0 and dig=dig+1, wrapping from NDIG-1 to 0; otherwise cnt increments.
REQ-016 Frame period SHALL be exactly NDIG*(BLANK+DWELL) cycles, with no idle cycles.
REQ-017 o_an and o_seg SHALL be registered and SHALL reflect the state of the previous cycle.
REQ-018 In BLANK: o_an=0 and o_seg=0.
REQ-019 In SHOW: o_an = 1<<dig.
REQ-020 In SHOW: o_seg = decode(disp nibble dig), unless that digit is blanked, in which case o_seg=0.
REQ-021 With i_lzb=1, a digit k>0 SHALL be blanked when nibbles k..NDIG-1 of disp are all zero; digit 0 is never blanked; o_an is still asserted for a blanked digit.
REQ-022 Handshake: a transfer occurs when i_valid && o_ready; i_value is captured into pend and pend_full is set on the next edge.
REQ-023 o_ready SHALL equal !pend_full, with no combinational path from i_valid.
REQ-024 Commit: on the SHOW->BLANK transition of digit NDIG-1, if pend_full, disp<=pend and pend_full<=0; disp SHALL never change mid-frame (no tearing).
REQ-025 A transfer in the same cycle as a commit SHALL NOT be included in that commit; it is applied at the next frame boundary.
REQ-026 o_frame SHALL assert for exactly the one cycle following the NDIG-1 SHOW->BLANK transition, whether or not a commit occurred.
REQ-027 i_valid while o_ready=0 SHALL be ignored; the producer holds i_valid, and pend is not overwritten.

Reset
REQ-028 While i_rst_n=0, the following SHALL hold immediately and asynchronously: state=BLANK, dig=0, cnt=0, disp=0, pend=0, pend_full=0, o_seg=0, o_an=0, o_frame=0, o_ready=1.
REQ-029 Reset asserted mid-frame SHALL discard any pending value; after release, scanning restarts from BLANK of digit 0.
REQ-030 After release, the first nonzero o_an SHALL appear BLANK+1 edges after the first rising edge of i_clk.

Structure
REQ-031 Package seg_pkg SHALL hold the FSM state typedef and the segment-off constant 7'h00.
REQ-032 SHALL instantiate exactly one existing display_decode, shared across all digits, fed by the nibble mux; no duplicate decode table.
REQ-033 Sub-module: none beyond display_decode; the target size is 120-250 RTL lines.

Verification (NDIG=2, DWELL=4, BLANK=2 unless noted)
REQ-034 Reset release with no input: o_an sequence 00,00,01x4,00,00,10x4 repeating; o_seg=7'h7E whenever o_an!=0; o_frame period 12 cycles.
REQ-035 Send i_value=8'h3A mid-frame: o_ready drops the next cycle; digits keep showing 7'h7E until o_frame; then digit0=7'h77 and digit1=7'h79; o_ready returns high with o_frame.
REQ-036 Hold i_valid with two values 8'h11 then 8'h22 back-to-back: the second is accepted only after the first commits; the display shows 11 for one frame, then 22.
REQ-037 i_lzb=1, value 8'h05: digit1 o_seg=0 with o_an=10; digit0 o_seg=7'h5B; value 8'h00 shows digit0 7'h7E and digit1 blank.
REQ-038 Transfer in the exact commit cycle: the old pend is displayed and the new value appears one frame later; no value is lost.
REQ-039 Assert i_rst_n=0 during SHOW of digit1 with pend_full=1: outputs clear in the same cycle; after release the display shows 0 and o_ready=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/display_decode.sv
// Hex nibble to seven-segment pattern, active high, bit 6 = a ... bit 0 = g.
module display_decode (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_nib)
      4'h0: o_seg = 7'h7E;
      4'h1: o_seg = 7'h30;
      4'h2: o_seg = 7'h6D;
      4'h3: o_seg = 7'h79;
      4'h4: o_seg = 7'h33;
      4'h5: o_seg = 7'h5B;
      4'h6: o_seg = 7'h5F;
      4'h7: o_seg = 7'h70;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h7B;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h1F;
      4'hC: o_seg = 7'h4E;
      4'hD: o_seg = 7'h3D;
      4'hE: o_seg = 7'h4F;
      4'hF: o_seg = 7'h47;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: blank/show per digit, with a one-deep
// pending buffer committed only at frame boundaries so the display never tears.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [4*NDIG-1:0] i_value,
  input  logic              i_lzb,
  output logic              o_ready,
  output logic [6:0]        o_seg,
  output logic [NDIG-1:0]   o_an,
  output logic              o_frame
);

  localparam int CW = $clog2((DWELL > BLANK) ? DWELL : BLANK);
  localparam int DW = $clog2(NDIG);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_dig;
  logic [4*NDIG-1:0] r_disp;
  logic [4*NDIG-1:0] r_pend;
  logic              r_pend_full;

  logic              w_show_end;
  logic              w_frame_end;
  logic              w_xfer;
  logic              w_blank;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;
  logic [4*NDIG-1:0] w_upper;

  assign w_show_end  = (r_state == ST_SHOW) && (r_cnt == CW'(DWELL - 1));
  assign w_frame_end = w_show_end && (r_dig == DW'(NDIG - 1));
  assign w_xfer      = i_valid && !r_pend_full;
  assign o_ready     = !r_pend_full;

  // Leading-zero test: the current digit and everything above it are zero.
  assign w_nib   = r_disp[4*r_dig +: 4];
  assign w_upper = r_disp >> (4 * r_dig);
  assign w_blank = i_lzb && (r_dig != '0) && (w_upper == '0);

  display_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_dig   <= '0;
      o_an    <= '0;
      o_seg   <= SEG_OFF;
      o_frame <= 1'b0;
    end else begin
      o_an    <= '0;
      o_seg   <= SEG_OFF;
      o_frame <= w_frame_end;
      if (r_state == ST_SHOW) begin
        o_an  <= NDIG'(1) << r_dig;
        o_seg <= w_blank ? SEG_OFF : w_seg;
      end
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == CW'(BLANK - 1)) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_show_end) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_dig   <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  // A transfer needs an empty buffer, so it can never coincide with a commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend      <= i_value;
      r_pend_full <= 1'b1;
    end else if (w_frame_end && r_pend_full) begin
      r_disp      <= r_pend;
      r_pend_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-indexed reference model, table of display
// vectors, directed handshake/reset corners and randomized producer traffic.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 2;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int PER   = BLANK + DWELL;
  localparam int FR    = NDIG * PER;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            lzb = 1'b0;
  logic [7:0]      value = '0;
  logic            ready;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;
  logic            frame;

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_value (value),
    .i_lzb   (lzb),
    .o_ready (ready),
    .o_seg   (seg),
    .o_an    (an),
    .o_frame (frame)
  );

  initial forever #5 clk = ~clk;

  int         errs = 0;
  int         checks = 0;
  int         c;
  logic [7:0] m_disp, m_pend;
  bit         m_pfull;
  logic [6:0] last_seg [NDIG];
  logic [6:0] segtab [16];

  typedef struct {
    logic [7:0] val;
    logic       lz;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg_of(input int d, input logic [7:0] disp, input logic lz);
    logic [3:0] n;
    logic [7:0] hi;
    n  = disp[4*d +: 4];
    hi = disp >> (4 * d);
    if (lz && d > 0 && hi == 8'h00) return 7'h00;
    return segtab[n];
  endfunction

  task automatic model_reset();
    c = 0; m_disp = '0; m_pend = '0; m_pfull = 0;
  endtask

  // One clock: predict from the position in the frame, advance, compare.
  task automatic step(output bit acc);
    int pos, d;
    bit show, fr;
    logic [NDIG-1:0] e_an;
    logic [6:0] e_seg;
    pos  = c % FR;
    d    = pos / PER;
    show = (pos % PER) >= BLANK;
    fr   = (pos == FR - 1);
    e_an = '0;
    if (show) e_an[d] = 1'b1;
    e_seg = show ? exp_seg_of(d, m_disp, lzb) : 7'h00;
    acc = valid && !m_pfull;
    if (acc) begin
      m_pend = value; m_pfull = 1;
    end else if (fr && m_pfull) begin
      m_disp = m_pend; m_pfull = 0;
    end
    c++;
    @(posedge clk); #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame", 32'(frame), 32'(fr));
    chk("ready", 32'(ready), 32'(!m_pfull));
    for (int i = 0; i < NDIG; i++) if (an[i]) last_seg[i] = seg;
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [7:0] v);
    bit a;
    a = 0;
    valid = 1'b1; value = v;
    for (int k = 0; k < 3 * FR && !a; k++) step(a);
    chk("accept", 32'(a), 32'd1);
    valid = 1'b0;
  endtask

  task automatic align(input int p);
    bit a;
    for (int k = 0; k < FR && (c % FR) != p; k++) step(a);
  endtask

  initial begin
    bit a;
    int apos;
    segtab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    tbl[0] = '{8'h3A, 1'b0, 7'h77, 7'h79};
    tbl[1] = '{8'h05, 1'b1, 7'h5B, 7'h00};
    tbl[2] = '{8'h00, 1'b1, 7'h7E, 7'h00};
    tbl[3] = '{8'h05, 1'b0, 7'h5B, 7'h7E};
    tbl[4] = '{8'hF8, 1'b0, 7'h7F, 7'h47};
    tbl[5] = '{8'h10, 1'b1, 7'h7E, 7'h30};
    tbl[6] = '{8'h2B, 1'b1, 7'h1F, 7'h6D};
    tbl[7] = '{8'h0C, 1'b0, 7'h4E, 7'h7E};
    for (int i = 0; i < NDIG; i++) last_seg[i] = 7'h00;
    model_reset();

    #12;
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Idle scanning: first lit digit after BLANK+1 edges, zeros displayed.
    run(2 * FR);
    chk("idle_d0", 32'(last_seg[0]), 32'h7E);
    chk("idle_d1", 32'(last_seg[1]), 32'h7E);

    for (int i = 0; i < 8; i++) begin
      lzb = tbl[i].lz;
      send(tbl[i].val);
      run(2 * FR + 2);
      chk("tbl_d0", 32'(last_seg[0]), 32'(tbl[i].s0));
      chk("tbl_d1", 32'(last_seg[1]), 32'(tbl[i].s1));
    end
    lzb = 1'b0;

    // Back-to-back held values: the second waits for the first to commit.
    send(8'h11);
    send(8'h22);
    run(2 * FR + 2);
    chk("b2b_d1", 32'(last_seg[1]), 32'h6D);

    // Transfer in the very cycle of a frame boundary.
    align(FR - 1);
    send(8'h47);
    run(FR);
    chk("commit_cyc_old", 32'(last_seg[1]), 32'h6D);
    run(FR + 2);
    chk("commit_cyc_new", 32'(last_seg[1]), 32'h33);

    // Held value behind a full buffer is taken right after the commit.
    align(0);
    send(8'h12);
    valid = 1'b1; value = 8'h34; a = 0;
    for (int k = 0; k < 3 * FR && !a; k++) step(a);
    apos = (c - 1) % FR;
    valid = 1'b0;
    chk("hold_accept_pos", 32'(apos), 32'd0);
    run(2 * FR + 2);

    // Randomized producer; it holds i_valid until accepted.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if (!valid && $urandom_range(0, 7) == 0) begin
        valid = 1'b1; value = 8'($urandom);
      end
      step(a);
      if (a) begin
        valid = ($urandom_range(0, 3) == 0);
        value = 8'($urandom);
      end
    end
    valid = 1'b0; lzb = 1'b0;
    run(2 * FR);

    // Reset during SHOW of digit 1 with a pending value.
    align(0);
    send(8'h99);
    align(PER + BLANK + 1);
    chk("pre_rst_pend", 32'(ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'd0);
    chk("async_seg", 32'(seg), 32'd0);
    chk("async_frame", 32'(frame), 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    run(2 * FR + 2);
    chk("post_rst_d0", 32'(last_seg[0]), 32'h7E);
    chk("post_rst_d1", 32'(last_seg[1]), 32'h7E);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
